adder_pipe: RTL

- Parametrised, pipelined successor to the single-bit full/half adder cells.
- Adds two WIDTH-bit operands plus carry-in. The carry chain is split into STAGES equal slices, one slice per register stage.
- Uses a valid/ready handshake on both sides, with per-stage bubble collapsing.
- Sits between operand producers and result consumers in the arithmetic datapath. Replaces the flat 32-bit ripple adder where timing closure fails.

---
 rtl/adder_pipe.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined WIDTH-bit adder with carry-in, split into STAGES equal
// carry-chain slices, one slice per register stage. Valid/ready handshake on
// both sides, with bubble collapsing between stages.
// Optional feature macro: ADDER_PIPE_OVERFLOW_EN adds a registered two's-complement
// overflow output that travels alongside sum/carry.
// WIDTH must be a multiple of STAGES.
`timescale 1ns/1ps

module adder_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef ADDER_PIPE_OVERFLOW_EN
   output logic             overflow,
`endif
   output logic             carry
);

   localparam int S = WIDTH / STAGES;

   logic [STAGES-1:0] validQ, validD;
   logic [STAGES-1:0] carryQ, carryD;
   logic [WIDTH-1:0]  sumQ [STAGES];
   logic [WIDTH-1:0]  sumD [STAGES];
   logic [WIDTH-1:0]  xQ   [STAGES];
   logic [WIDTH-1:0]  xD   [STAGES];
   logic [WIDTH-1:0]  yQ   [STAGES];
   logic [WIDTH-1:0]  yD   [STAGES];
   logic [STAGES-1:0] advance;
   logic              initQ;
`ifdef ADDER_PIPE_OVERFLOW_EN
   logic              ovfQ, ovfD;
`endif

   // Stage k may load when it or any stage downstream holds a bubble, or the consumer is ready
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         advance[k] = out_ready;
         for (int j = k; j < STAGES; j++) begin
            if (!validQ[j]) begin
               advance[k] = 1'b1;
            end
         end
      end
   end

   assign in_ready = initQ && advance[0];

   // Next-state for every stage: valid always follows the upstream beat, data only on a real beat
   always_comb begin
      logic             srcValid;
      logic             srcCarry;
      logic [WIDTH-1:0] srcX;
      logic [WIDTH-1:0] srcY;
      logic [WIDTH-1:0] srcSum;
      logic [S-1:0]     xs;
      logic [S-1:0]     ys;
      logic [S-1:0]     s;
      logic             co;
      validD   = validQ;
      carryD   = carryQ;
      srcValid = 1'b0;
      srcCarry = 1'b0;
      srcX     = '0;
      srcY     = '0;
      srcSum   = '0;
      xs       = '0;
      ys       = '0;
      s        = '0;
      co       = 1'b0;
`ifdef ADDER_PIPE_OVERFLOW_EN
      ovfD     = ovfQ;
`endif
      for (int k = 0; k < STAGES; k++) begin
         sumD[k] = sumQ[k];
         xD[k]   = xQ[k];
         yD[k]   = yQ[k];
      end
      for (int k = 0; k < STAGES; k++) begin
         if (k == 0) begin
            srcValid = in_valid && in_ready;
            srcCarry = c_in;
            srcX     = x_in;
            srcY     = y_in;
            srcSum   = '0;
         end else begin
            srcValid = validQ[k-1];
            srcCarry = carryQ[k-1];
            srcX     = xQ[k-1];
            srcY     = yQ[k-1];
            srcSum   = sumQ[k-1];
         end
         if (advance[k]) begin
            validD[k] = srcValid;
            if (srcValid) begin
               xs      = srcX[k*S +: S];
               ys      = srcY[k*S +: S];
               {co, s} = {1'b0, xs} + {1'b0, ys} + {{S{1'b0}}, srcCarry};
               sumD[k]            = srcSum;
               sumD[k][k*S +: S]  = s;
               carryD[k]          = co;
               xD[k]              = srcX;
               xD[k][k*S +: S]    = '0;
               yD[k]              = srcY;
               yD[k][k*S +: S]    = '0;
`ifdef ADDER_PIPE_OVERFLOW_EN
               if (k == STAGES - 1) begin
                  ovfD = co ^ (s[S-1] ^ xs[S-1] ^ ys[S-1]);
               end
`endif
            end
         end
      end
   end

   // Stage registers; reset clears everything and holds off in_ready until the first edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         validQ <= '0;
         carryQ <= '0;
         initQ  <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            sumQ[k] <= '0;
            xQ[k]   <= '0;
            yQ[k]   <= '0;
         end
`ifdef ADDER_PIPE_OVERFLOW_EN
         ovfQ   <= 1'b0;
`endif
      end else begin
         validQ <= validD;
         carryQ <= carryD;
         initQ  <= 1'b1;
         for (int k = 0; k < STAGES; k++) begin
            sumQ[k] <= sumD[k];
            xQ[k]   <= xD[k];
            yQ[k]   <= yD[k];
         end
`ifdef ADDER_PIPE_OVERFLOW_EN
         ovfQ   <= ovfD;
`endif
      end
   end

   assign out_valid = validQ[STAGES-1];
   assign sum       = sumQ[STAGES-1];
   assign carry     = carryQ[STAGES-1];
`ifdef ADDER_PIPE_OVERFLOW_EN
   assign overflow  = ovfQ;
`endif

endmodule
